// File: rtl/opl3_pkg.sv
// Shared constants for the OPL3 timer/status stage.
package opl3_pkg;

  localparam int REG_TIMER_WIDTH = 8;

  // Sample-enable pulses per timer tick: 80 us and 320 us at ~49.7 kHz.
  localparam int TIMER1_TICK_SAMPLES_DEFAULT = 4;
  localparam int TIMER2_TICK_SAMPLES_DEFAULT = 16;

  // Bit positions inside the host status byte.
  localparam int STATUS_IRQ_BIT = 7;
  localparam int STATUS_FT1_BIT = 6;
  localparam int STATUS_FT2_BIT = 5;

  // Build the status byte from the two overflow flags.
  function automatic logic [7:0] pack_status(input logic ft1, input logic ft2);
    logic [7:0] s;
    s                 = 8'h00;
    s[STATUS_IRQ_BIT] = ft1 | ft2;
    s[STATUS_FT1_BIT] = ft1;
    s[STATUS_FT2_BIT] = ft2;
    return s;
  endfunction

endpackage

// File: rtl/opl3_timers_if.sv
// Register-file -> timer stage bus. OPL3_TIMER_COUNT_READBACK_EN adds the
// live counter values for debug readback.
interface opl3_timers_if;
  import opl3_pkg::*;

  logic                       sample_clk_en;
  logic [REG_TIMER_WIDTH-1:0] timer1;
  logic [REG_TIMER_WIDTH-1:0] timer2;
  logic                       irq_rst;
  logic                       mt1;
  logic                       mt2;
  logic                       st1;
  logic                       st2;
  logic                       ft1;
  logic                       ft2;
  logic                       irq;
  logic                       irq_n;
  logic [7:0]                 status;
`ifdef OPL3_TIMER_COUNT_READBACK_EN
  logic [REG_TIMER_WIDTH-1:0] timer1_count;
  logic [REG_TIMER_WIDTH-1:0] timer2_count;
`endif

  // Register-file side drives presets/control and reads flags.
  modport master (
    output sample_clk_en, timer1, timer2, irq_rst, mt1, mt2, st1, st2,
`ifdef OPL3_TIMER_COUNT_READBACK_EN
    input  timer1_count, timer2_count,
`endif
    input  ft1, ft2, irq, irq_n, status
  );

  // Timer stage side.
  modport slave (
    input  sample_clk_en, timer1, timer2, irq_rst, mt1, mt2, st1, st2,
`ifdef OPL3_TIMER_COUNT_READBACK_EN
    output timer1_count, timer2_count,
`endif
    output ft1, ft2, irq, irq_n, status
  );

endinterface

// File: rtl/opl3_timer_channel.sv
// One OPL3 hardware timer: free-running prescaler, start-edge detect,
// up-counter with reload, masked sticky overflow flag.
// OPL3_TIMER_COUNT_READBACK_EN exposes the counter register as count_o.
module opl3_timer_channel
  import opl3_pkg::*;
#(
  parameter int TICK_SAMPLES = TIMER1_TICK_SAMPLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_clk_en_i,
  input  logic [REG_TIMER_WIDTH-1:0] preset_i,
  input  logic                       irq_rst_i,
  input  logic                       mask_i,
  input  logic                       run_i,
`ifdef OPL3_TIMER_COUNT_READBACK_EN
  output logic [REG_TIMER_WIDTH-1:0] count_o,
`endif
  output logic                       flag_o
);

  localparam int PW = (TICK_SAMPLES > 1) ? $clog2(TICK_SAMPLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_SAMPLES - 1);

  logic [PW-1:0]              presc_q, presc_d;
  logic [REG_TIMER_WIDTH-1:0] cnt_q, cnt_d;
  logic                       run_q;
  logic                       flag_q, flag_d;
  logic                       tick, start, ovf;

  // Prescaler ticks on the wrapping sample pulse; start wins over a same-clk
  // tick; a run drop on the overflow clk suppresses the overflow entirely.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    tick    = sample_clk_en_i && (presc_q == PRESC_LAST);
    start   = run_i && !run_q;
    ovf     = run_i && !start && tick && (cnt_q == '1);

    if (sample_clk_en_i)
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);

    if (start)
      cnt_d = preset_i;
    else if (run_i && tick)
      cnt_d = ovf ? preset_i : cnt_q + REG_TIMER_WIDTH'(1);

    if (irq_rst_i)
      flag_d = 1'b0;
    else if (ovf && !mask_i)
      flag_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_i;
      flag_q  <= flag_d;
    end
  end

  assign flag_o = flag_q;
`ifdef OPL3_TIMER_COUNT_READBACK_EN
  assign count_o = cnt_q;
`endif

endmodule

// File: rtl/opl3_timers.sv
// OPL3 timer/status stage: two timer channels, IRQ and status byte.
// OPL3_TIMER_COUNT_READBACK_EN adds timer1_count/timer2_count on the bus.
module opl3_timers
  import opl3_pkg::*;
#(
  parameter int TIMER1_TICK_SAMPLES = TIMER1_TICK_SAMPLES_DEFAULT,
  parameter int TIMER2_TICK_SAMPLES = TIMER2_TICK_SAMPLES_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  opl3_timers_if.slave bus
);

  logic ft1, ft2;

  opl3_timer_channel #(.TICK_SAMPLES(TIMER1_TICK_SAMPLES)) u_t1 (
    .clk             (clk),
    .reset           (reset),
    .sample_clk_en_i (bus.sample_clk_en),
    .preset_i        (bus.timer1),
    .irq_rst_i       (bus.irq_rst),
    .mask_i          (bus.mt1),
    .run_i           (bus.st1),
`ifdef OPL3_TIMER_COUNT_READBACK_EN
    .count_o         (bus.timer1_count),
`endif
    .flag_o          (ft1)
  );

  opl3_timer_channel #(.TICK_SAMPLES(TIMER2_TICK_SAMPLES)) u_t2 (
    .clk             (clk),
    .reset           (reset),
    .sample_clk_en_i (bus.sample_clk_en),
    .preset_i        (bus.timer2),
    .irq_rst_i       (bus.irq_rst),
    .mask_i          (bus.mt2),
    .run_i           (bus.st2),
`ifdef OPL3_TIMER_COUNT_READBACK_EN
    .count_o         (bus.timer2_count),
`endif
    .flag_o          (ft2)
  );

  // Flags are registered in the channels; everything below is combinational.
  always_comb begin
    bus.ft1    = ft1;
    bus.ft2    = ft2;
    bus.irq    = ft1 | ft2;
    bus.irq_n  = ~(ft1 | ft2);
    bus.status = pack_status(ft1, ft2);
  end

endmodule

// File: tb/tb_opl3_timers.sv
// Scoreboarded bench for opl3_timers. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_opl3_timers;
  import opl3_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  opl3_timers_if bus ();
  opl3_timers dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  string      q_tag[$];
  logic [7:0] q_exp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected status is queued with the stimulus that should produce it.
  task automatic sb_push(input string tag, input logic [7:0] v);
    q_tag.push_back(tag);
    q_exp.push_back(v);
  endtask

  task automatic sb_check();
    if (q_exp.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      chk(q_tag.pop_front(), {24'h0, bus.status}, {24'h0, q_exp.pop_front()});
    end
  endtask

  // One sample pulse; entered and left on a falling edge.
  task automatic pulse();
    bus.sample_clk_en = 1'b1;
    @(negedge clk);
    bus.sample_clk_en = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.st1 = 1'b0; bus.st2 = 1'b0; bus.mt1 = 1'b0; bus.mt2 = 1'b0;
    bus.irq_rst = 1'b0;
    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
  endtask

  initial begin
    bus.sample_clk_en = 1'b0;
    bus.timer1 = 8'h00; bus.timer2 = 8'h00;
    @(negedge clk);

    // Reset state
    sb_push("reset_status", 8'h00);
    do_reset();
    sb_check();
    chk("reset_irq_n", {31'h0, bus.irq_n}, 32'd1);
`ifdef OPL3_TIMER_COUNT_READBACK_EN
    chk("reset_cnt1", {24'h0, bus.timer1_count}, 32'h0);
`endif

    // Preset 0xFE: overflow on the 2nd tick = 8th pulse
    bus.timer1 = 8'hFE; bus.st1 = 1'b1;
    idle();
    sb_push("t1_fe_p7", 8'h00);
    pulses(7);
    sb_check();
    sb_push("t1_fe_p8", 8'hC0);
    pulse();
    sb_check();
    chk("t1_fe_irq_n", {31'h0, bus.irq_n}, 32'd0);
    chk("t1_fe_irq", {31'h0, bus.irq}, 32'd1);

    // Preset 0xFF: overflow each tick, irq_rst clears, mt1 rise keeps flag
    do_reset();
    bus.timer1 = 8'hFF; bus.st1 = 1'b1;
    idle();
    sb_push("t1_ff_p3", 8'h00);
    pulses(3);
    sb_check();
    sb_push("t1_ff_p4", 8'hC0);
    pulse();
    sb_check();
    bus.irq_rst = 1'b1;
    sb_push("t1_ff_clr", 8'h00);
    idle();
    sb_check();
    bus.irq_rst = 1'b0;
    sb_push("t1_ff_p7", 8'h00);
    pulses(3);
    sb_check();
    sb_push("t1_ff_p8", 8'hC0);
    pulse();
    sb_check();
    bus.mt1 = 1'b1;
    sb_push("t1_mask_keeps", 8'hC0);
    idle();
    sb_check();
    // Masked overflow still reloads, flag cleared and not set again
    bus.irq_rst = 1'b1; idle(); bus.irq_rst = 1'b0;
    sb_push("t1_masked_ovf", 8'h00);
    pulses(4);
    sb_check();

    // Timer 2 masked, then unmasked: overflows at ticks 2 and 4 (pulses 32, 64)
    do_reset();
    bus.timer2 = 8'hFE; bus.mt2 = 1'b1; bus.st2 = 1'b1;
    idle();
    sb_push("t2_masked_p32", 8'h00);
    pulses(32);
    sb_check();
    bus.mt2 = 1'b0;
    idle();
    sb_push("t2_p48", 8'h00);
    pulses(16);
    sb_check();
    sb_push("t2_p63", 8'h00);
    pulses(15);
    sb_check();
    sb_push("t2_p64", 8'hA0);
    pulse();
    sb_check();

    // irq_rst high on the overflow clk wins
    do_reset();
    bus.timer1 = 8'hFF; bus.st1 = 1'b1;
    idle();
    pulses(3);
    bus.irq_rst = 1'b1;
    sb_push("irqrst_vs_ovf", 8'h00);
    pulse();
    sb_check();
    bus.irq_rst = 1'b0;
    sb_push("irqrst_next_ovf", 8'hC0);
    pulses(4);
    sb_check();

    // st1 falling on the overflow clk cancels the overflow
    do_reset();
    bus.timer1 = 8'hFF; bus.st1 = 1'b1;
    idle();
    pulses(3);
    bus.st1 = 1'b0;
    sb_push("stop_cancels", 8'h00);
    pulse();
    sb_check();

    // Stop after 2 ticks, restart at 0x10: 240 ticks to overflow
    do_reset();
    bus.timer1 = 8'h00; bus.st1 = 1'b1;
    idle();
    pulses(8);
    bus.st1 = 1'b0;
    pulses(4);
`ifdef OPL3_TIMER_COUNT_READBACK_EN
    chk("hold_cnt1", {24'h0, bus.timer1_count}, 32'h02);
`endif
    bus.timer1 = 8'h10; bus.st1 = 1'b1;
    idle();
`ifdef OPL3_TIMER_COUNT_READBACK_EN
    chk("restart_cnt1", {24'h0, bus.timer1_count}, 32'h10);
`endif
    sb_push("restart_t239", 8'h00);
    pulses(239 * 4);
    sb_check();
    sb_push("restart_t240", 8'hC0);
    pulses(4);
    sb_check();

    // Both timers at 0xFF; ft2 joins on pulse 16; reset clears everything
    do_reset();
    bus.timer1 = 8'hFF; bus.timer2 = 8'hFF;
    bus.st1 = 1'b1; bus.st2 = 1'b1;
    idle();
    sb_push("both_p15", 8'hC0);
    pulses(15);
    sb_check();
    sb_push("both_p16", 8'hE0);
    pulse();
    sb_check();
    reset = 1'b1;
    sb_push("midrun_reset", 8'h00);
    idle();
    sb_check();
    chk("midrun_irq_n", {31'h0, bus.irq_n}, 32'd1);
`ifdef OPL3_TIMER_COUNT_READBACK_EN
    chk("midrun_cnt2", {24'h0, bus.timer2_count}, 32'h0);
`endif
    reset = 1'b0;

    chk("sb_drained", q_exp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
